// File: rtl/cpu_clk_ctrl.sv
// CPU clock generator: programmable half-period divider with run/halt/step modes,
// PC breakpoint and a count of cpu_clk rising edges.
module cpu_clk_ctrl #(
  parameter int DIV_W = 24,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_val,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_clk,
  output logic             tick,
  output logic             halted,
  output logic             brk_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BRK} state_t;

  localparam logic [1:0] M_HALT = 2'b00;
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;
  localparam logic [1:0] M_BRK  = 2'b11;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             step_q, step_d;

  logic [DIV_W-1:0] div_eff;
  logic             half_done;
  logic             step_edge;
  logic             bp_match;

  always_comb begin
    div_eff   = (div_val == '0) ? DIV_W'(1) : div_val;
    // >= rather than == so a shrinking div_val ends the current half at once instead of wrapping
    half_done = (cnt_q >= div_eff - DIV_W'(1));
    step_edge = step_req & ~step_q;
    bp_match  = (pc == bp_addr);

    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_clk_d   = cpu_clk_q;
    tick_d      = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
    step_d      = step_req;

    case (state_q)
      S_HALT: begin
        cnt_d     = '0;
        cpu_clk_d = 1'b0;
        if (mode == M_RUN)
          state_d = S_RUN;
        else if (mode == M_BRK)
          state_d = bp_match ? S_BRK : S_RUN;
        else if (mode == M_STEP && step_edge)
          state_d = S_STEP;
      end
      S_RUN, S_STEP: begin
        if (half_done) begin
          cnt_d     = '0;
          cpu_clk_d = ~cpu_clk_q;
          if (!cpu_clk_q) begin
            tick_d      = 1'b1;
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          end else if (state_q == S_STEP) begin
            state_d = S_HALT;
          end else begin
            // End of a full cycle: the only point where RUN may stop
            case (mode)
              M_HALT, M_STEP: state_d = S_HALT;
              M_BRK:          if (bp_match) state_d = S_BRK;
              default:        state_d = S_RUN;
            endcase
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_BRK: begin
        cnt_d     = '0;
        cpu_clk_d = 1'b0;
        if (step_edge)
          state_d = S_STEP;
        else if (mode == M_RUN)
          state_d = S_RUN;
        else if (mode != M_BRK)
          state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HALT;
      cnt_q       <= '0;
      cpu_clk_q   <= 1'b0;
      tick_q      <= 1'b0;
      cycle_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_clk_q   <= cpu_clk_d;
      tick_q      <= tick_d;
      cycle_cnt_q <= cycle_cnt_d;
      step_q      <= step_d;
    end
  end

  assign cpu_clk   = cpu_clk_q;
  assign tick      = tick_q;
  assign cycle_cnt = cycle_cnt_q;
  assign halted    = (state_q == S_HALT) || (state_q == S_BRK);
  assign brk_hit   = (state_q == S_BRK);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: expected cpu_clk/tick timelines are computed arithmetically
// from the number of board clocks elapsed since run/step entry.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] div_val;
  logic [1:0]  mode;
  logic        step_req;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_clk, tick, halted, brk_hit;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  cpu_clk_ctrl #(.DIV_W(24), .PC_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .div_val(div_val), .mode(mode), .step_req(step_req),
    .bp_addr(bp_addr), .pc(pc), .cpu_clk(cpu_clk), .tick(tick), .halted(halted),
    .brk_hit(brk_hit), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // m = board clocks since entry: low for d, high for d, repeating; rises at m = d, 3d, 5d...
  function automatic logic m_clk(int m, int d);
    return (m >= d) && (((m / d) % 2) == 1);
  endfunction

  function automatic logic m_tick(int m, int d);
    return (m >= d) && ((m % (2 * d)) == d);
  endfunction

  task automatic do_reset();
    reset = 1'b1; mode = 2'b00; step_req = 1'b0; pc = '0; bp_addr = '0; div_val = 24'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'b00; step_req = 1'b0; pc = '0; bp_addr = '0; div_val = 24'd1;
    #1;
    checks++; if (cpu_clk !== 1'b0) begin errors++; $display("FAIL reset_cpu_clk got=%b exp=0", cpu_clk); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got=%b exp=1", halted); end
    checks++; if (brk_hit !== 1'b0) begin errors++; $display("FAIL reset_brk got=%b exp=0", brk_hit); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (cpu_clk !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_idle clk=%b halted=%b exp clk=0 halted=1", cpu_clk, halted);
      end
    end
  endtask

  task automatic test_run(int dv);
    int d = (dv == 0) ? 1 : dv;
    int exp_cnt = 0;
    do_reset();
    div_val = 24'(dv);
    mode = 2'b01;
    for (int m = 0; m < 10 * d; m++) begin
      @(negedge clk);
      if (m_tick(m, d)) exp_cnt++;
      checks++;
      if (cpu_clk !== m_clk(m, d) || tick !== m_tick(m, d) || halted !== 1'b0) begin
        errors++;
        $display("FAIL run d=%0d m=%0d clk=%b tick=%b halted=%b exp clk=%b tick=%b halted=0",
                 d, m, cpu_clk, tick, halted, m_clk(m, d), m_tick(m, d));
      end
      step_req = 1'($urandom_range(0, 1));
    end
    step_req = 1'b0;
    checks++;
    if (cycle_cnt !== 32'(exp_cnt)) begin
      errors++; $display("FAIL run_count d=%0d got=%0d exp=%0d", d, cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_step(int d);
    do_reset();
    div_val = 24'(d);
    mode = 2'b10;
    step_req = 1'b1;
    for (int m = 0; m <= 4 * d; m++) begin
      @(negedge clk);
      checks++;
      if (cpu_clk !== (m >= d && m < 2 * d) || tick !== (m == d) || halted !== (m >= 2 * d)) begin
        errors++;
        $display("FAIL step d=%0d m=%0d clk=%b tick=%b halted=%b exp clk=%b tick=%b halted=%b",
                 d, m, cpu_clk, tick, halted, (m >= d && m < 2 * d), (m == d), (m >= 2 * d));
      end
      if (m == 0) step_req = 1'b0;
      if (m == d) step_req = 1'b1;
      if (m == d + 1) step_req = 1'b0;
    end
    checks++;
    if (cycle_cnt !== 32'd1) begin
      errors++; $display("FAIL step_count got=%0d exp=1", cycle_cnt);
    end
  endtask

  task automatic test_halt_mid_run(int d);
    logic ec, et;
    do_reset();
    div_val = 24'(d);
    mode = 2'b01;
    for (int m = 0; m < 10 * d; m++) begin
      @(negedge clk);
      ec = (m < 4 * d) ? m_clk(m, d) : 1'b0;
      et = (m < 4 * d) ? m_tick(m, d) : 1'b0;
      checks++;
      if (cpu_clk !== ec || tick !== et || halted !== (m >= 4 * d)) begin
        errors++;
        $display("FAIL halt_mid d=%0d m=%0d clk=%b tick=%b halted=%b exp clk=%b tick=%b halted=%b",
                 d, m, cpu_clk, tick, halted, ec, et, (m >= 4 * d));
      end
      if (m == 3 * d) mode = 2'b00;
    end
    checks++;
    if (cycle_cnt !== 32'd2) begin
      errors++; $display("FAIL halt_mid_count got=%0d exp=2", cycle_cnt);
    end
  endtask

  task automatic test_breakpoint(int d, int k);
    logic prev = 1'b0;
    logic ec;
    do_reset();
    div_val = 24'(d);
    bp_addr = 32'(4 * k);
    mode = 2'b11;
    for (int m = 0; m < 2 * k * d + 3 * d; m++) begin
      @(negedge clk);
      ec = (m < 2 * k * d) ? m_clk(m, d) : 1'b0;
      checks++;
      if (cpu_clk !== ec || brk_hit !== (m >= 2 * k * d) || halted !== (m >= 2 * k * d)) begin
        errors++;
        $display("FAIL bp_run d=%0d k=%0d m=%0d clk=%b brk=%b halted=%b exp clk=%b brk=%b",
                 d, k, m, cpu_clk, brk_hit, halted, ec, (m >= 2 * k * d));
      end
      if (cpu_clk && !prev) pc = pc + 32'd4;
      prev = cpu_clk;
    end
    checks++;
    if (pc !== 32'(4 * k) || cycle_cnt !== 32'(k)) begin
      errors++; $display("FAIL bp_stop pc=%0h cnt=%0d exp pc=%0h cnt=%0d", pc, cycle_cnt, 4 * k, k);
    end
    step_req = 1'b1;
    for (int m = 0; m <= 3 * d; m++) begin
      @(negedge clk);
      checks++;
      if (cpu_clk !== (m >= d && m < 2 * d) || brk_hit !== 1'b0 || halted !== (m >= 2 * d)) begin
        errors++;
        $display("FAIL bp_step m=%0d clk=%b brk=%b halted=%b exp clk=%b brk=0 halted=%b",
                 m, cpu_clk, brk_hit, halted, (m >= d && m < 2 * d), (m >= 2 * d));
      end
      if (m == 0) begin step_req = 1'b0; mode = 2'b00; end
      if (cpu_clk && !prev) pc = pc + 32'd4;
      prev = cpu_clk;
    end
    checks++;
    if (pc !== 32'(4 * k + 4) || cycle_cnt !== 32'(k + 1)) begin
      errors++; $display("FAIL bp_after pc=%0h cnt=%0d exp pc=%0h cnt=%0d", pc, cycle_cnt, 4 * k + 4, k + 1);
    end
  endtask

  task automatic test_bp_on_entry(int d);
    do_reset();
    div_val = 24'(d);
    pc = 32'h40; bp_addr = 32'h40;
    mode = 2'b11;
    for (int m = 0; m < 2 * d + 2; m++) begin
      @(negedge clk);
      checks++;
      if (brk_hit !== 1'b1 || cpu_clk !== 1'b0 || cycle_cnt !== 32'd0) begin
        errors++; $display("FAIL bp_entry m=%0d brk=%b clk=%b cnt=%0d exp brk=1 clk=0 cnt=0",
                           m, brk_hit, cpu_clk, cycle_cnt);
      end
    end
    mode = 2'b01;
    for (int m = 0; m < 3 * d; m++) begin
      @(negedge clk);
      checks++;
      if (cpu_clk !== m_clk(m, d) || brk_hit !== 1'b0) begin
        errors++; $display("FAIL brk_to_run m=%0d clk=%b brk=%b exp clk=%b brk=0", m, cpu_clk, brk_hit, m_clk(m, d));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int d = 3;
    int n = 0;
    do_reset();
    div_val = 24'(d);
    mode = 2'b01;
    do begin @(negedge clk); n++; end while (cpu_clk !== 1'b1 && n < 40);
    checks++;
    if (cpu_clk !== 1'b1) begin errors++; $display("FAIL mid_wait timeout clk=%b exp=1", cpu_clk); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cpu_clk !== 1'b0 || cycle_cnt !== 32'd0 || halted !== 1'b1) begin
      errors++; $display("FAIL async_reset clk=%b cnt=%0d halted=%b exp clk=0 cnt=0 halted=1", cpu_clk, cycle_cnt, halted);
    end
    #1 reset = 1'b0;
    #0;
    checks++;
    if (halted !== 1'b1 || cpu_clk !== 1'b0) begin
      errors++; $display("FAIL post_reset halted=%b clk=%b exp halted=1 clk=0", halted, cpu_clk);
    end
    for (int m = 0; m < 4 * d; m++) begin
      @(negedge clk);
      checks++;
      if (cpu_clk !== m_clk(m, d) || halted !== 1'b0) begin
        errors++; $display("FAIL restart m=%0d clk=%b halted=%b exp clk=%b halted=0", m, cpu_clk, halted, m_clk(m, d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_run(2);
    test_run(0);
    test_run(1);
    repeat (3) test_run($urandom_range(1, 6));
    test_step(3);
    test_step($urandom_range(2, 6));
    test_halt_mid_run(4);
    test_halt_mid_run($urandom_range(1, 5));
    test_breakpoint(2, 3);
    test_breakpoint($urandom_range(1, 4), $urandom_range(1, 4));
    test_bp_on_entry($urandom_range(1, 4));
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
